// File: rtl/dff_trick_sched_if.sv
// Port bundle between requesters/shared flop and the dff_trick_sched scheduler.
// The slave modport is the scheduler's view; the master modport is the requester/flop side.
interface dff_trick_sched_if #(
    parameter int N_REQ = 4,
    parameter int EN_W  = 5
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      req_d;
    logic [N_REQ*EN_W-1:0] req_en;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      done;
    logic                  rsp_q;
    logic                  busy;
    logic                  ff_d;
    logic [EN_W-1:0]       ff_en;
    logic                  ff_is_diff;
    logic                  ff_q;
    logic [1:0]            dbg_state;

    modport slave (
        input  req, req_d, req_en, ff_q,
        output gnt, done, rsp_q, busy, ff_d, ff_en, ff_is_diff, dbg_state
    );

    modport master (
        output req, req_d, req_en, ff_q,
        input  gnt, done, rsp_q, busy, ff_d, ff_en, ff_is_diff, dbg_state
    );
endinterface

// File: rtl/dff_trick_sched.sv
// Round-robin scheduler sharing one d_ff_trick flop among N_REQ requesters.
// Grants one request at a time, waits SETTLE_CYC cycles, returns the sampled q with a done pulse.
module dff_trick_sched #(
    parameter int N_REQ      = 4,
    parameter int EN_W       = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    dff_trick_sched_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     ptr, ptr_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              lat_d, lat_d_nx;
    logic [EN_W-1:0]   lat_en, lat_en_nx;
    logic [EN_W-1:0]   last_en, last_en_nx;
    logic              last_valid, last_valid_nx;
    logic [N_REQ-1:0]  done_r, done_nx;
    logic              rsp_r, rsp_nx;

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic [N_REQ-1:0]  idx_oh;

    // Handshake: a requester raises req with req_d/req_en stable and holds it
    // until it sees its gnt bit (a one-cycle pulse); it must drop req the next
    // cycle. done[i] pulses for one cycle when rsp_q carries that requester's result.

    // First set req bit at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign idx_oh = {{(N_REQ-1){1'b0}}, 1'b1} << idx;

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        idx_nx        = idx;
        cnt_nx        = cnt;
        lat_d_nx      = lat_d;
        lat_en_nx     = lat_en;
        last_en_nx    = last_en;
        last_valid_nx = last_valid;
        done_nx       = '0;
        rsp_nx        = rsp_r;
        case (state)
            S_IDLE: begin
                if (found) begin
                    idx_nx    = pick;
                    lat_d_nx  = bus.req_d[pick];
                    lat_en_nx = bus.req_en[int'(pick)*EN_W +: EN_W];
                    state_nx  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (SETTLE_CYC > 0) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 4'(SETTLE_CYC - 1);
                end else begin
                    state_nx = S_RESP;
                    done_nx  = idx_oh;
                    rsp_nx   = bus.ff_q;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                    done_nx  = idx_oh;
                    rsp_nx   = bus.ff_q;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RESP: begin
                last_en_nx    = lat_en;
                last_valid_nx = 1'b1;
                ptr_nx        = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
                state_nx      = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            idx        <= '0;
            cnt        <= '0;
            lat_d      <= 1'b0;
            lat_en     <= '0;
            last_en    <= '0;
            last_valid <= 1'b0;
            done_r     <= '0;
            rsp_r      <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            lat_d      <= lat_d_nx;
            lat_en     <= lat_en_nx;
            last_en    <= last_en_nx;
            last_valid <= last_valid_nx;
            done_r     <= done_nx;
            rsp_r      <= rsp_nx;
        end
    end

    // The latched request only changes on a new grant, so driving the flop
    // straight from it holds d/en steady between transactions.
    assign bus.ff_d       = lat_d;
    assign bus.ff_en      = lat_en;
    assign bus.ff_is_diff = (state == S_ISSUE) && (!last_valid || (lat_en != last_en));
    assign bus.gnt        = (state == S_ISSUE) ? idx_oh : '0;
    assign bus.done       = done_r;
    assign bus.rsp_q      = rsp_r;
    assign bus.busy       = (state != S_IDLE);
    assign bus.dbg_state  = state;
endmodule
